// File: rtl/ms_mem_slave.sv
// Bus slave endpoint: word-addressed register memory with programmable ack wait
// states and a fixed-latency read-response pipeline.
module ms_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int ACK_WAIT   = 1,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  cmd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  resp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                               state, state_nxt;
  logic [7:0]                           cnt, cnt_nxt;
  logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [RD_LATENCY:1]                  vld_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0]  data_pipe;
  logic [IDX_W-1:0]                     idx;
  logic                                 in_range;
  logic                                 cap;
  logic                                 rd_fire;
  logic                                 wr_fire;
  logic [DATA_WIDTH-1:0]                rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= (state_nxt == ACK);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (ACK_WAIT == 0) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 8'(ACK_WAIT);
          end
        end
      end
      WAIT: begin
        // Master withdrawing req here aborts with no side effects.
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 8'd1) begin
          state_nxt = ACK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Capture on the edge that ends the ack cycle; req gates it so inputs are
  // never sampled while the master is not driving them.
  assign cap      = ack && req;
  assign idx      = addr[IDX_W-1:0];
  assign in_range = ((addr >> IDX_W) == '0);
  assign rd_fire  = cap && !cmd;
  assign wr_fire  = cap && cmd && in_range;
  assign rd_word  = in_range ? mem[idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_fire) begin
      mem[idx] <= wdata;
    end
  end

  // Data stages are zeroed when invalid so rdata reads 0 outside resp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1]  <= rd_fire;
      data_pipe[1] <= rd_fire ? rd_word : '0;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign resp  = vld_pipe[RD_LATENCY];
  assign rdata = data_pipe[RD_LATENCY];

endmodule

// File: tb/tb_ms_mem_slave.sv
// Scoreboard bench: two slaves (default timing, and zero-wait/latency-4),
// directed transactions, a negedge monitor checking every read response.
module tb_ms_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, cmd0, ack0, resp0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, cmd1, ack1, resp1;
  logic [31:0] addr1, wdata1, rdata1;

  ms_mem_slave u0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr0), .cmd(cmd0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .resp(resp0)
  );

  ms_mem_slave #(.ACK_WAIT(0), .RD_LATENCY(4)) u1 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr1), .cmd(cmd1), .wdata(wdata1),
    .ack(ack1), .rdata(rdata1), .resp(resp1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int rd_lat(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int ack_lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic mon(input int d, input logic r, input logic [31:0] rd);
    exp_t e;
    bit   empty;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (r) begin
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp%0d: got resp with rdata %h want no resp", d, rd);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("resp%0d_data", d), rd, e.data);
        chk($sformatf("resp%0d_cycle", d), cyc, e.at);
      end
    end else begin
      chk($sformatf("rdata%0d_idle", d), rd, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, resp0, rdata0);
    mon(1, resp1, rdata1);
  end

  task automatic drive(input int d, input logic r, input logic c,
                       input logic [31:0] a, input logic [31:0] w);
    if (d == 0) begin
      req0 = r; cmd0 = c; addr0 = a; wdata0 = w;
    end else begin
      req1 = r; cmd1 = c; addr1 = a; wdata1 = w;
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that ends
  // the ack cycle. ack_at is -1 when no ack arrived within the budget.
  task automatic txn(input int d, input logic c, input logic [31:0] a,
                     input logic [31:0] w, input bit hold,
                     output int ack_at, output logic rs_at_ack);
    int   start;
    int   n;
    logic ak;
    start     = cyc;
    ak        = 1'b0;
    rs_at_ack = 1'b0;
    n         = 0;
    drive(d, 1'b1, c, a, w);
    while (!ak && n < 40) begin
      @(negedge clk);
      n++;
      ak        = (d == 0) ? ack0 : ack1;
      rs_at_ack = (d == 0) ? resp0 : resp1;
    end
    if (!ak) begin
      total++;
      bad++;
      $display("FAIL ack_timeout%0d: got no ack after %0d cycles want ack", d, n);
      ack_at = -1;
    end else begin
      ack_at = cyc;
      chk($sformatf("ack_latency%0d", d), cyc - start, ack_lat(d));
    end
    @(posedge clk);
    #1;
    if (!hold) drive(d, 1'b0, 1'b0, 'x, 'x);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] w, input bit hold);
    int   t;
    logic b;
    txn(d, 1'b1, a, w, hold, t, b);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] want,
                    input bit hold, output int ack_at, output logic rs_at_ack);
    exp_t e;
    txn(d, 1'b0, a, 'x, hold, ack_at, rs_at_ack);
    if (ack_at >= 0) begin
      e.data = want;
      e.at   = ack_at + rd_lat(d);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  initial begin
    int   a1, a2, a3, t;
    logic b, b3;
    drive(0, 1'b0, 1'b0, 'x, 'x);
    drive(1, 1'b0, 1'b0, 'x, 'x);
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_resp0", resp0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_resp1", resp1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ack0", ack0, 0);
      chk("idle_ack1", ack1, 0);
    end
    @(posedge clk);
    #1;

    // Default timing: write then read back
    wr(0, 32'd3, 32'hDEADBEEF, 1'b0);
    rd(0, 32'd3, 32'hDEADBEEF, 1'b0, t, b);

    // Out of range: write dropped (would alias mem[0]), read returns 0
    wr(0, 32'd16, 32'h0000_1234, 1'b0);
    rd(0, 32'd16, 32'h0, 1'b0, t, b);
    rd(0, 32'd0, 32'h0, 1'b0, t, b);

    // Abort in WAIT
    drive(0, 1'b1, 1'b1, 32'd3, 32'hBAD0BAD0);
    @(negedge clk);
    chk("abort_ack_idle", ack0, 0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 'x, 'x);
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_ack", ack0, 0);
    end
    @(posedge clk);
    #1;
    rd(0, 32'd3, 32'hDEADBEEF, 1'b0, t, b);

    // Zero-wait slave: preload, back-to-back reads, read-before-write hazard
    wr(1, 32'd1, 32'h11, 1'b0);
    wr(1, 32'd2, 32'h22, 1'b0);
    wr(1, 32'd5, 32'h55, 1'b0);
    rd(1, 32'd1, 32'h11, 1'b1, a1, b);
    rd(1, 32'd2, 32'h22, 1'b1, a2, b);
    rd(1, 32'd5, 32'h55, 1'b1, a3, b3);
    wr(1, 32'd5, 32'hAA, 1'b0);
    chk("b2b_ack_gap_1", a2 - a1, 2);
    chk("b2b_ack_gap_2", a3 - a2, 2);
    chk("ack_with_resp", b3, 1);
    rd(1, 32'd5, 32'hAA, 1'b0, t, b);

    repeat (8) @(posedge clk);
    #1;
    chk("drain_before_reset", q0.size() + q1.size(), 0);

    // Reset one cycle after a read's ack: its response must never appear
    txn(1, 1'b0, 32'd2, 'x, 1'b0, t, b);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rd(1, 32'd2, 32'h0, 1'b0, t, b);
    rd(0, 32'd3, 32'h0, 1'b0, t, b);

    repeat (8) @(posedge clk);
    #1;
    chk("drain_final", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ms_mem_slave.md
Name: ms_mem_slave

Overview:
- Slave-side responder for the master/slave req/ack/resp bus. Its ports are the SLAVE modport signal set.
- Terminates one bus port in a word-addressed register memory, with a programmable number of ack wait states and a fixed read-response latency.
- Used as the endpoint behind router output ports, and as a bus-functional target for master-side verification.

Parameters:
DATA_WIDTH, 32, width of wdata/rdata
ADDR_WIDTH, 32, width of addr (word address)
MEM_DEPTH, 16, number of DATA_WIDTH words; power of two, >=2
ACK_WAIT, 1, wait-state cycles inserted before ack (0..255)
RD_LATENCY, 2, cycles from ack cycle to resp pulse (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
req  input  1  master request, held until ack observed
addr  input  ADDR_WIDTH  word address
cmd  input  1  0 = read, 1 = write
wdata  input  DATA_WIDTH  write data, valid with req
ack  output  1  registered one-cycle accept strobe
rdata  output  DATA_WIDTH  read data, valid only while resp=1, else 0
resp  output  1  registered one-cycle read-data strobe

Behaviour:
- Reset (async, rst=1):
  - ack=0, resp=0, rdata=0.
  - FSM=IDLE, wait counter=0, all read-pipeline valid bits cleared, all memory words=0.
  - Reset mid-transaction discards the pending ack and all in-flight read responses; none appear after reset release.
- FSM states:
  - IDLE: if req=1 → ACK when ACK_WAIT=0, else → WAIT with cnt=ACK_WAIT. If req=0, stay in IDLE.
  - WAIT: if req=0 → IDLE (abort: no ack, no memory or pipeline side effect). Else if cnt=1 → ACK. Else cnt-1, stay in WAIT.
  - ACK: ack=1 for exactly this cycle. The transaction is captured at the clock edge ending this cycle, using addr/cmd/wdata sampled at that edge. Always → IDLE.
- Timing:
  - req first seen in IDLE in cycle N → ack high in cycle N+1+ACK_WAIT.
  - Maximum throughput is one transaction per ACK_WAIT+2 cycles. A master holding req high through the ack edge starts a new transaction evaluated in IDLE the next cycle.
- Address decode:
  - In range when addr < MEM_DEPTH; index = addr[$clog2(MEM_DEPTH)-1:0].
  - Out of range: write is acked and dropped; read is acked and returns 0.
- Write (cmd=1): mem[index] <= wdata at the capture edge. No resp is generated.
- Read (cmd=0):
  - mem[index] is sampled at the capture edge, before any write at the same edge (none is possible, since one transaction per edge).
  - The sampled word enters a RD_LATENCY-stage valid/data shift pipeline. resp=1 and rdata=word exactly RD_LATENCY cycles after the ack cycle, for one cycle.
  - Responses return in acceptance order.
  - A write accepted after a read but before its resp does not change that read's data.
- resp has no backpressure. The pipeline cannot overflow, because at most ceil(RD_LATENCY/(ACK_WAIT+2)) reads are in flight.
- ack and resp may be high in the same cycle (new accept plus old read response).
- Inputs are ignored when req=0. X on addr/wdata while req=0 must not propagate to state.

Test Plan:
- Reset check: hold rst=1 → ack=0, resp=0, rdata=0. After release with req=0 for 10 cycles, all outputs remain 0.
- Write then read (defaults): write addr=3, wdata=0xDEADBEEF, req from cycle 0 → ack in cycle 2. Read addr=3 starting cycle 3 → ack in cycle 5, resp=1 with rdata=0xDEADBEEF in cycle 7 only.
- Back-to-back ordering, ACK_WAIT=0, RD_LATENCY=4: preload mem[1]=0x11, mem[2]=0x22, then issue reads addr=1 and addr=2 with req held high. Acks land 2 cycles apart; resps land 2 cycles apart in order 0x11 then 0x22; in one cycle ack=1 and resp=1 together.
- Read-before-write hazard, ACK_WAIT=0, RD_LATENCY=4: read addr=5 (contains 0x55), then immediately write addr=5 with 0xAA. The resp carries 0x55; a subsequent read of addr=5 returns 0xAA.
- Out of range: write addr=16 with 0x1234 → ack asserted, mem unchanged. Read addr=16 → resp with rdata=0. Read addr=0 → still 0.
- Abort and reset: drop req in WAIT → no ack, FSM back in IDLE. Issue a read, assert rst 1 cycle after its ack → no resp ever appears; after release a read of a previously written address returns 0.
